// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - CPU bus responder for RAM, LEDs, switches and an optional countdown timer
//
// Optional feature macro: MIO_COUNTER_EN (counter, reload, control, status registers and INT).
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   req        in   CPU access valid, held until MIO_ready
//   mem_w      in   1 = write, 0 = read
//   Addr_in    in   32-bit CPU byte address (bits [1:0] ignored)
//   Data_in    in   32-bit CPU write data
//   Data_out   out  32-bit read data, valid while MIO_ready = 1
//   MIO_ready  out  one-cycle completion pulse
//   INT        out  level interrupt (pending & int_en)
//   ram_addr   out  RAM word address
//   ram_we     out  RAM write enable
//   ram_din    out  RAM write data
//   ram_dout   in   RAM read data (synchronous RAM, 1-cycle read)
//   sw_in      in   16 switches
//   led_out    out  16 LEDs

module mio_bus_responder #(
  parameter int RAM_WAIT = 1,
  parameter int RAM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mem_w,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Data_in,
  output logic [31:0]       Data_out,
  output logic              MIO_ready,
  output logic              INT,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
);

  // Word addresses (byte address >> 2) of the register map.
  localparam logic [29:0] A_LED    = 30'h3800_0000;
  localparam logic [29:0] A_SW     = 30'h3C00_0000;
  localparam logic [29:0] A_CNT    = 30'h3C00_0001;
  localparam logic [29:0] A_CTRL   = 30'h3C00_0002;
  localparam logic [29:0] A_RELOAD = 30'h3C00_0003;
  localparam logic [29:0] A_STAT   = 30'h3C00_0004;

  localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        start;
  logic [3:0]  wait_cnt;
  logic [29:0] word_addr;
  logic        sel_ram;
  logic        sel_led;
  logic        sel_sw;
  logic        wr_fire;
  logic [31:0] rd_mux;
  logic [31:0] tmr_rdata;
  logic        unused_addr_lsb;

  assign word_addr       = Addr_in[31:2];
  assign unused_addr_lsb = &{1'b0, Addr_in[1:0]};
  assign sel_ram         = (Addr_in[31:RAM_AW+2] == '0);
  assign sel_led         = (word_addr == A_LED);
  assign sel_sw          = (word_addr == A_SW);

  // Address and data are held by the CPU for the whole access, so the RAM
  // sees a stable address from IDLE through WAIT.
  assign ram_addr  = Addr_in[RAM_AW+1:2];
  assign ram_din   = Data_in;

  // All write side effects happen on the single IDLE->ACK edge; reset masks
  // that edge so an aborted access leaves no trace.
  assign wr_fire   = start && mem_w && !reset;
  assign ram_we    = wr_fire && sel_ram;
  assign MIO_ready = (state == S_ACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          start     = 1'b1;
          state_nxt = (sel_ram && !mem_w) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        // req is deliberately not looked at here; the next access begins in IDLE.
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_mux = tmr_rdata;
    if (sel_led) begin
      rd_mux = {16'h0000, led_out};
    end else if (sel_sw) begin
      rd_mux = {16'h0000, sw_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd1;
      Data_out <= '0;
      led_out  <= '0;
    end else begin
      // wait_cnt counts WAIT cycles starting at 1 on entry.
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= 4'd1;
      end
      if (start && !mem_w && !sel_ram) begin
        Data_out <= rd_mux;
      end
      if (state == S_WAIT && wait_cnt == WAIT_LAST) begin
        Data_out <= ram_dout;
      end
      if (wr_fire && sel_led) begin
        led_out <= Data_in[15:0];
      end
    end
  end

`ifdef MIO_COUNTER_EN
  logic [31:0] counter;
  logic [31:0] reload;
  logic        run;
  logic        auto_rl;
  logic        int_en;
  logic        pending;
  logic        reload_pend;
  logic        wr_cnt;
  logic        wr_ctrl;
  logic        wr_reload;
  logic        wr_stat;
  logic        underflow;

  assign wr_cnt    = wr_fire && (word_addr == A_CNT);
  assign wr_ctrl   = wr_fire && (word_addr == A_CTRL);
  assign wr_reload = wr_fire && (word_addr == A_RELOAD);
  assign wr_stat   = wr_fire && (word_addr == A_STAT);

  // Only a real 1->0 step counts; a CPU write to the counter in the same
  // cycle replaces the decrement and so cancels the event.
  assign underflow = run && (counter == 32'd1) && !wr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      counter     <= '0;
      reload      <= '0;
      run         <= 1'b0;
      auto_rl     <= 1'b0;
      int_en      <= 1'b0;
      pending     <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      reload_pend <= underflow && auto_rl;
      if (wr_cnt) begin
        counter <= Data_in;
      end else if (reload_pend) begin
        counter <= reload;
      end else if (run && counter != 32'd0) begin
        counter <= counter - 32'd1;
      end
      if (wr_ctrl) begin
        {int_en, auto_rl, run} <= Data_in[2:0];
      end else if (underflow && !auto_rl) begin
        run <= 1'b0;
      end
      if (wr_reload) begin
        reload <= Data_in;
      end
      // A new underflow beats a simultaneous clear so no event is lost.
      if (underflow) begin
        pending <= 1'b1;
      end else if (wr_stat && Data_in[0]) begin
        pending <= 1'b0;
      end
    end
  end

  assign INT = pending & int_en;

  always_comb begin
    tmr_rdata = '0;
    case (word_addr)
      A_CNT:    tmr_rdata = counter;
      A_CTRL:   tmr_rdata = {29'h0, int_en, auto_rl, run};
      A_RELOAD: tmr_rdata = reload;
      A_STAT:   tmr_rdata = {31'h0, pending};
      default:  tmr_rdata = '0;
    endcase
  end
`else
  assign tmr_rdata = '0;
  assign INT       = 1'b0;
`endif

endmodule
